// File: rtl/mix_pkg.sv
// Shared types and constants for the mix-round stream checker.
package mix_pkg;

  localparam int NUM_LANES  = 8;
  localparam int NUM_PASSES = 16;

  typedef logic [31:0] word_t;
  typedef logic [NUM_LANES-1:0][31:0] state_t;

  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} step_e;
  typedef enum logic [1:0] {ST_RESET, ST_COMPUTE, ST_RECV} fsm_e;

  localparam word_t M1 [NUM_LANES] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
  localparam word_t C1 [NUM_LANES] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
  localparam word_t M2 [NUM_LANES] = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd5, 32'd13, 32'd35, 32'd87};
  localparam word_t C2 [NUM_LANES] = '{32'd0, 32'd1, 32'd8, 32'd27, 32'd64, 32'd125, 32'd216, 32'd343};

  // Seed state: lane k holds k.
  function automatic state_t init_state();
    state_t s;
    for (int k = 0; k < NUM_LANES; k++) begin
      s[k] = word_t'(k);
    end
    return s;
  endfunction

endpackage

// File: rtl/mix_pass.sv
// Combinational evaluator for one mix step; lanes update in order, in place.
module mix_pass
  import mix_pkg::*;
(
  input  state_t state_in,
  input  step_e  step,
  output state_t state_out
);

  state_t     work_s;
  logic [2:0] kk_s;

  // Sequential in-place lane update; 3-bit lane indices wrap mod 8 by width.
  always_comb begin
    work_s = state_in;
    kk_s   = 3'd0;
    for (int k = 0; k < NUM_LANES; k++) begin
      kk_s = 3'(k);
      case (step)
        S0: work_s[kk_s] = work_s[kk_s] + {29'd0, kk_s};
        S1: work_s[kk_s] = work_s[kk_s] + work_s[kk_s + 3'd7];
        S2: work_s[kk_s] = work_s[kk_s] + work_s[kk_s + 3'd1] - work_s[kk_s + 3'd5];
        S3: work_s[kk_s] = work_s[kk_s] ^ (work_s[kk_s + 3'd3] << 5'd16);
        S4: work_s[kk_s] = work_s[kk_s] - (work_s[kk_s + 3'd2] >> 5'd17)
                           + (work_s[kk_s + 3'd4] >> 5'd12);
        S5: work_s[kk_s] = work_s[kk_s] + work_s[kk_s + 3'd7] - work_s[kk_s + 3'd6];
        S6: work_s[kk_s] = work_s[kk_s] * M1[kk_s] + C1[kk_s];
        S7: work_s[kk_s] = work_s[kk_s] * M2[kk_s] + C2[kk_s];
        default: work_s[kk_s] = work_s[kk_s];
      endcase
    end
  end

  assign state_out = work_s;

endmodule

// File: rtl/mix_stream_checker.sv
// Self-checking sink for the mix-round generator stream.
// Optional MIX_CHK_RESYNC_EN: reseed the expected state from a failing frame.
module mix_stream_checker
  import mix_pkg::*;
#(
  parameter int CNT_W            = 16,
  parameter int PASSES_PER_CYCLE = 1
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [2:0]       mismatch_lane,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  localparam logic [3:0] PASS_STEP = 4'(PASSES_PER_CYCLE);
  localparam logic [3:0] LAST_PASS = 4'(NUM_PASSES - PASSES_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  fsm_e             state_r;
  state_t           s_r;
  logic [3:0]       pass_cnt_r;
  logic [2:0]       beat_r;
  logic             bad_seen_r;
  logic [2:0]       bad_lane_r;
  logic             in_ready_r;
  logic             busy_r;
  logic             frame_done_r;
  logic             frame_ok_r;
  logic [2:0]       mismatch_lane_r;
  logic [CNT_W-1:0] frame_count_r;
  logic [CNT_W-1:0] err_count_r;
`ifdef MIX_CHK_RESYNC_EN
  logic [6:0][31:0] rx_r;
`endif

  logic       accept_s;
  logic       frame_bad_s;
  logic [2:0] lane_s;
  state_t     chain_s [PASSES_PER_CYCLE+1];

  assign chain_s[0] = s_r;

  for (genvar g = 0; g < PASSES_PER_CYCLE; g++) begin : g_pass
    logic [2:0] step_s;
    assign step_s = 3'((pass_cnt_r + 4'(g)) >> 3'd1);
    mix_pass u_pass (
      .state_in  (chain_s[g]),
      .step      (step_e'(step_s)),
      .state_out (chain_s[g+1])
    );
  end

  // Per-beat compare result folded with earlier beats of the frame.
  always_comb begin
    accept_s    = in_valid & in_ready_r;
    frame_bad_s = bad_seen_r | (in_data != s_r[beat_r]);
    if (bad_seen_r) begin
      lane_s = bad_lane_r;
    end else begin
      lane_s = beat_r;
    end
  end

  // Control FSM, expected-state engine and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_RESET;
      s_r             <= init_state();
      pass_cnt_r      <= 4'd0;
      beat_r          <= 3'd0;
      bad_seen_r      <= 1'b0;
      bad_lane_r      <= 3'd0;
      in_ready_r      <= 1'b0;
      busy_r          <= 1'b0;
      frame_done_r    <= 1'b0;
      frame_ok_r      <= 1'b0;
      mismatch_lane_r <= 3'd0;
      frame_count_r   <= '0;
      err_count_r     <= '0;
`ifdef MIX_CHK_RESYNC_EN
      rx_r            <= '0;
`endif
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        ST_RESET: begin
          state_r <= ST_COMPUTE;
          busy_r  <= 1'b1;
        end
        ST_COMPUTE: begin
          s_r        <= chain_s[PASSES_PER_CYCLE];
          pass_cnt_r <= pass_cnt_r + PASS_STEP;
          if (pass_cnt_r == LAST_PASS) begin
            state_r    <= ST_RECV;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b1;
          end
        end
        ST_RECV: begin
          if (accept_s) begin
            if (beat_r == 3'd7) begin
              frame_done_r  <= 1'b1;
              frame_ok_r    <= ~frame_bad_s;
              frame_count_r <= frame_count_r + CNT_ONE;
              if (frame_bad_s) begin
                mismatch_lane_r <= lane_s;
                if (err_count_r != CNT_MAX) begin
                  err_count_r <= err_count_r + CNT_ONE;
                end
`ifdef MIX_CHK_RESYNC_EN
                s_r <= {in_data, rx_r};
`endif
              end
              beat_r     <= 3'd0;
              bad_seen_r <= 1'b0;
              bad_lane_r <= 3'd0;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b1;
              state_r    <= ST_COMPUTE;
            end else begin
              beat_r     <= beat_r + 3'd1;
              bad_seen_r <= frame_bad_s;
              bad_lane_r <= lane_s;
`ifdef MIX_CHK_RESYNC_EN
              rx_r[beat_r] <= in_data;
`endif
            end
          end
        end
        default: begin
          state_r    <= ST_RESET;
          busy_r     <= 1'b0;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_r;
  assign busy          = busy_r;
  assign frame_done    = frame_done_r;
  assign frame_ok      = frame_ok_r;
  assign mismatch_lane = mismatch_lane_r;
  assign frame_count   = frame_count_r;
  assign err_count     = err_count_r;

endmodule

// File: tb/tb_mix_stream_checker.sv
// Directed scoreboard bench for mix_stream_checker (CNT_W=4 to reach saturation quickly).
module tb_mix_stream_checker;

  localparam int P = 1;
  localparam int BUSY_CYCLES = 16 / P;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        frame_done;
  logic        frame_ok;
  logic [2:0]  mismatch_lane;
  logic [3:0]  frame_count;
  logic [3:0]  err_count;
  logic        busy;

  mix_stream_checker #(.CNT_W(4), .PASSES_PER_CYCLE(P)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .frame_done    (frame_done),
    .frame_ok      (frame_ok),
    .mismatch_lane (mismatch_lane),
    .frame_count   (frame_count),
    .err_count     (err_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ok;
    logic [2:0] lane;
    logic [3:0] fc;
    logic [3:0] ec;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [31:0] ms [8];
  logic [3:0]  fc_m;
  logic [3:0]  ec_m;
  logic [2:0]  lane_m;

  int m1 [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
  int c1 [8] = '{3, 5, 7, 11, 13, 17, 19, 23};
  int m2 [8] = '{2, 3, 3, 3, 5, 13, 35, 87};
  int c2 [8] = '{0, 1, 8, 27, 64, 125, 216, 343};

  always @(negedge clk) begin
    if (rst_n && frame_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 8; k++) ms[k] = k;
    fc_m = 4'd0;
    ec_m = 4'd0;
    lane_m = 3'd0;
    sb.delete();
  endfunction

  // Golden round: 16 passes, step = pass/2, lanes updated in place.
  function automatic void model_round();
    for (int p = 0; p < 16; p++) begin
      for (int k = 0; k < 8; k++) begin
        case (p / 2)
          0: ms[k] = ms[k] + k;
          1: ms[k] = ms[k] + ms[(k + 7) % 8];
          2: ms[k] = ms[k] + ms[(k + 1) % 8] - ms[(k + 5) % 8];
          3: ms[k] = ms[k] ^ (ms[(k + 3) % 8] << 16);
          4: ms[k] = ms[k] - (ms[(k + 2) % 8] >> 17) + (ms[(k + 4) % 8] >> 12);
          5: ms[k] = ms[k] + ms[(k + 7) % 8] - ms[(k + 6) % 8];
          6: ms[k] = ms[k] * m1[k] + c1[k];
          default: ms[k] = ms[k] * m2[k] + c2[k];
        endcase
      end
    end
  endfunction

  task automatic drive_beats(input logic [31:0] w [8], input bit gaps, input int stop);
    int k = 0;
    int guard = 0;
    while (k < stop && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = w[k];
        if (in_ready) k++;
      end
    end
    chk("beat_budget", k, stop);
  endtask

  task automatic count_idle(input string tag);
    int cnt = 0;
    while (!in_ready && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk(tag, cnt, BUSY_CYCLES);
  endtask

  task automatic check_done();
    exp_t e;
    @(negedge clk);
    in_valid = 1'b0;
    chk("frame_done", frame_done, 1'b1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("frame_ok", frame_ok, e.ok);
      chk("mismatch_lane", mismatch_lane, e.lane);
      chk("frame_count", frame_count, e.fc);
      chk("err_count", err_count, e.ec);
    end
    count_idle("idle_after_frame");
  endtask

  task automatic run_frame(input int bad_lane, input bit gaps);
    logic [31:0] w [8];
    exp_t e;
    model_round();
    for (int k = 0; k < 8; k++) w[k] = ms[k];
    if (bad_lane >= 0) begin
      w[bad_lane] = w[bad_lane] ^ 32'h1;
      lane_m = 3'(bad_lane);
      if (ec_m != 4'hF) ec_m = ec_m + 4'd1;
`ifdef MIX_CHK_RESYNC_EN
      for (int k = 0; k < 8; k++) ms[k] = w[k];
`endif
    end
    fc_m = fc_m + 4'd1;
    e.ok = (bad_lane < 0);
    e.lane = lane_m;
    e.fc = fc_m;
    e.ec = ec_m;
    sb.push_back(e);
    drive_beats(w, gaps, 8);
    check_done();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_done"}, frame_done, 1'b0);
    chk({tag, "_ok"}, frame_ok, 1'b0);
    chk({tag, "_lane"}, mismatch_lane, 3'd0);
    chk({tag, "_fc"}, frame_count, 4'd0);
    chk({tag, "_ec"}, err_count, 4'd0);
    chk({tag, "_ready"}, in_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic release_and_wait();
    int cnt = 0;
    rst_n = 1'b1;
    chk("busy_before_first_edge", busy, 1'b0);
    @(negedge clk);
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_cycles", cnt, BUSY_CYCLES);
    chk("ready_after_compute", in_ready, 1'b1);
  endtask

  initial begin
    int d0;
    logic [31:0] w [8];
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    release_and_wait();

    // Gap-free correct frames.
    for (int i = 0; i < 10; i++) run_frame(-1, 1'b0);
    chk("fc_after_10", frame_count, 4'd10);
    chk("ec_after_10", err_count, 4'd0);

    // One corrupted frame, then the follow-up frame against the model.
    run_frame(3, 1'b0);
    run_frame(-1, 1'b0);

    // Random valid gaps.
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) run_frame(-1, 1'b1);
    chk("done_pulses_gapped", done_cnt - d0, 4);

    // Reset in the middle of a frame after 5 accepted beats.
    model_round();
    for (int k = 0; k < 8; k++) w[k] = ms[k];
    drive_beats(w, 1'b0, 5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midframe_reset");
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    release_and_wait();
    run_frame(-1, 1'b0);

    // Saturate err_count with failing frames.
    for (int i = 0; i < 17; i++) run_frame(i % 8, 1'b0);
    chk("err_saturated", err_count, 4'hF);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mix_stream_checker.md
Name: mix_stream_checker

Overview:
- Receive end of the mix-round workload: consumes the 8×32-bit state stream produced each clock by the mix-round generator, one word per beat.
- Independently recomputes the expected state with a multi-cycle iterative engine.
- Compares every received word against the expected state and reports per-frame pass/fail and running counters.
- Sits beside the generator as its self-checking sink in simulation and in emulation builds.

Parameters:
- CNT_W, 16: width of frame_count and err_count.
- PASSES_PER_CYCLE, 1: mix passes evaluated per compute cycle; legal values 1 or 2. Compute latency is 16/PASSES_PER_CYCLE cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  word valid.
- in_ready  out  1  checker can accept a word.
- in_data  in  32  state word; beat k of a frame carries o[k], k=0..7.
- frame_done  out  1  one-cycle pulse after beat 7 of a frame is accepted.
- frame_ok  out  1  result of the last completed frame; valid while frame_done=1 and held until the next frame_done.
- mismatch_lane  out  3  lowest k that mismatched in the last failing frame.
- frame_count  out  CNT_W  frames completed; wraps.
- err_count  out  CNT_W  failing frames; saturates at all-ones.
- busy  out  1  engine computing.

Behaviour:
- State s[0..7], 32-bit, all arithmetic mod 2^32.
- Shifts are logical.
- Indices are taken mod 8.
- A step updates k=0..7 in order, in place; later k sees the new values of earlier k.
- Steps:
  - S0: s[k]+=k
  - S1: s[k]+=s[k-1]
  - S2: s[k]=s[k]+s[k+1]-s[k+5]
  - S3: s[k]^=s[k+3]<<16
  - S4: s[k]=s[k]-(s[k+2]>>17)+(s[k+4]>>12)
  - S5: s[k]=s[k]+s[k-1]-s[k-2]
  - S6: s[k]=s[k]*M1[k]+C1[k]
  - S7: s[k]=s[k]*M2[k]+C2[k]
- Step constants:
  - M1={2,3,5,7,11,13,17,19}
  - C1={3,5,7,11,13,17,19,23}
  - M2={2,3,3,3,5,13,35,87}
  - C2={0,1,8,27,64,125,216,343}
- A round is 16 passes: S0,S0,S1,S1,…,S7,S7.
- FSM states:
  - RESET: s[k]=k, counters 0, frame_ok=0, mismatch_lane=0, frame_done=0, in_ready=0, busy=0. The first cycle after reset release enters COMPUTE.
  - COMPUTE: busy=1, in_ready=0. Runs PASSES_PER_CYCLE passes per cycle with a 4-bit pass counter, then goes to RECV.
  - RECV: in_ready=1. A beat is accepted when in_valid&&in_ready, and beat counter k advances 0..7. in_data is compared to s[k] on the accept cycle, and the first mismatching k is latched. An in_valid=0 cycle stalls the beat with no penalty.
  - On accepting beat 7: the next cycle pulses frame_done, updates frame_ok, mismatch_lane, frame_count (+1) and err_count (+1 if failed, saturating), then enters COMPUTE.
- mismatch_lane is only updated on failing frames.
- Reset asserted mid-compute or mid-frame: everything returns to RESET values immediately; the partial frame is discarded.
- The expected state advances exactly one round per completed frame, regardless of pass/fail.

Optional Feature:
- Macro MIX_CHK_RESYNC_EN.
- Defined: on a failing frame, the received 8 words, buffered as they arrive, replace s before the next COMPUTE, so the checker re-locks to a generator that skipped or slipped rounds.
- Undefined: no receive buffer; s always evolves from its own previous value.

Decomposition:
- Package mix_pkg:
  - word_t (32-bit)
  - NUM_LANES=8
  - NUM_PASSES=16
  - step enum S0..S7
  - M1/C1/M2/C2 constant arrays
- Sub-module mix_pass: combinational one-step evaluator; inputs state and step id, output next state.
- The checker instantiates PASSES_PER_CYCLE copies of mix_pass in a chain.

Test Plan:
- Reset release -> busy=1 for exactly 16 cycles (8 with PASSES_PER_CYCLE=2), then in_ready=1; all counters and flags 0.
- Stream 10 correct frames from the bench model, gap-free -> 10 frame_done pulses, each with frame_ok=1; frame_count=10, err_count=0; each frame is followed by 16 cycles of in_ready=0.
- Frame 2 with beat 3 XOR 0x1 -> that frame_done has frame_ok=0, mismatch_lane=3, err_count=1. Without resync, frame 3 matches the model; with MIX_CHK_RESYNC_EN, frame 3 matches the model reseeded from the corrupted frame.
- Random in_valid gaps (50% duty) -> results identical to the gap-free run; frame_done is asserted once per 8 accepted beats.
- Assert rst_n low at beat 5 of frame 4 -> outputs return to reset values asynchronously; the next accepted frame is checked against round(init).
- Force err_count to near-saturation (CNT_W=4, 17 failing frames) -> err_count holds at 15.
